// File: rtl/tlul_host_leds.sv
// TL-UL single-beat host: turns a local request/response port into Get/PutFullData/PutPartialData
// transactions with one outstanding request and a D-channel response timeout.
module tlul_host_leds #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SRCW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [AW-1:0]     i_req_addr,
    input  logic [DW-1:0]     i_req_wdata,
    input  logic [DW/8-1:0]   i_req_mask,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_rsp_error,
    output logic              o_a_valid,
    input  logic              i_a_ready,
    output logic [2:0]        o_a_opcode,
    output logic [2:0]        o_a_param,
    output logic [1:0]        o_a_size,
    output logic [SRCW-1:0]   o_a_source,
    output logic [AW-1:0]     o_a_address,
    output logic [DW/8-1:0]   o_a_mask,
    output logic [DW-1:0]     o_a_data,
    input  logic              i_d_valid,
    output logic              o_d_ready,
    input  logic [2:0]        i_d_opcode,
    input  logic [SRCW-1:0]   i_d_source,
    input  logic [DW-1:0]     i_d_data,
    input  logic              i_d_error
);
    localparam int unsigned   MW             = DW / 8;
    localparam int unsigned   TW             = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST        = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [1:0]    SIZE           = 2'($clog2(MW));
    localparam logic [2:0]    OP_GET         = 3'd4;
    localparam logic [2:0]    OP_PUT_FULL    = 3'd0;
    localparam logic [2:0]    OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0]    OP_ACK         = 3'd0;
    localparam logic [2:0]    OP_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {StIdle, StASend, StDWait, StRsp} state_e;

    state_e          state_q, state_d;
    logic [2:0]      a_opcode_q, a_opcode_d;
    logic [AW-1:0]   a_address_q, a_address_d;
    logic [MW-1:0]   a_mask_q, a_mask_d;
    logic [DW-1:0]   a_data_q, a_data_d;
    logic [SRCW-1:0] src_q, src_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;
    logic [2:0]      exp_d_opcode;

    assign exp_d_opcode = (a_opcode_q == OP_GET) ? OP_ACK_DATA : OP_ACK;

    always_comb begin
        state_d     = state_q;
        a_opcode_d  = a_opcode_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        src_d       = src_q;
        tmo_d       = tmo_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    state_d     = StASend;
                    a_address_d = i_req_addr;
                    if (!i_req_write) begin
                        a_opcode_d = OP_GET;
                        a_mask_d   = '1;
                        a_data_d   = '0;
                    end else begin
                        a_opcode_d = (&i_req_mask) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                        a_mask_d   = i_req_mask;
                        a_data_d   = i_req_wdata;
                    end
                end
            end
            StASend: begin
                if (i_a_ready) begin
                    state_d = StDWait;
                    tmo_d   = '0;
                end
            end
            StDWait: begin
                if (i_d_valid) begin
                    state_d     = StRsp;
                    rsp_rdata_d = (i_d_opcode == OP_ACK_DATA) ? i_d_data : '0;
                    rsp_error_d = i_d_error | (i_d_source != src_q) |
                                  (i_d_opcode != exp_d_opcode);
                end else if ((TIMEOUT != 0) && (tmo_q == TO_LAST)) begin
                    // This cycle's increment would reach TIMEOUT: give up on the slave.
                    state_d     = StRsp;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StRsp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                    src_d   = src_q + SRCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            a_opcode_q  <= '0;
            a_address_q <= '0;
            a_mask_q    <= '0;
            a_data_q    <= '0;
            src_q       <= '0;
            tmo_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_opcode_q  <= a_opcode_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            src_q       <= src_d;
            tmo_q       <= tmo_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign o_req_ready = (state_q == StIdle);
    assign o_a_valid   = (state_q == StASend);
    assign o_d_ready   = (state_q == StDWait);
    assign o_rsp_valid = (state_q == StRsp);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_error = rsp_error_q;
    assign o_a_opcode  = a_opcode_q;
    assign o_a_param   = 3'd0;
    assign o_a_size    = SIZE;
    assign o_a_source  = src_q;
    assign o_a_address = a_address_q;
    assign o_a_mask    = a_mask_q;
    assign o_a_data    = a_data_q;

endmodule

// File: tb/tb_tlul_host_leds.sv
// Bench for tlul_host_leds: directed and randomized transactions checked against a
// transaction-level model of the expected A-channel fields and responses.
module tb_tlul_host_leds;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SRCW = 8;
    localparam int MW = DW / 8;
    localparam int TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready, req_write;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [MW-1:0]   req_mask;
    logic            rsp_valid, rsp_ready, rsp_error;
    logic [DW-1:0]   rsp_rdata;
    logic            a_valid, a_ready;
    logic [2:0]      a_opcode, a_param;
    logic [1:0]      a_size;
    logic [SRCW-1:0] a_source;
    logic [AW-1:0]   a_address;
    logic [MW-1:0]   a_mask;
    logic [DW-1:0]   a_data;
    logic            d_valid, d_ready, d_error;
    logic [2:0]      d_opcode;
    logic [SRCW-1:0] d_source;
    logic [DW-1:0]   d_data;

    tlul_host_leds #(.AW(AW), .DW(DW), .SRCW(SRCW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_mask(req_mask),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error),
        .o_a_valid(a_valid), .i_a_ready(a_ready), .o_a_opcode(a_opcode), .o_a_param(a_param),
        .o_a_size(a_size), .o_a_source(a_source), .o_a_address(a_address), .o_a_mask(a_mask),
        .o_a_data(a_data),
        .i_d_valid(d_valid), .o_d_ready(d_ready), .i_d_opcode(d_opcode),
        .i_d_source(d_source), .i_d_data(d_data), .i_d_error(d_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: transaction count since reset and the request in flight.
    int            exp_src = 0;
    logic          cur_write;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [MW-1:0] cur_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_opcode();
        if (!cur_write) return 3'd4;
        if (cur_mask == 4'hF) return 3'd0;
        return 3'd1;
    endfunction

    task automatic check_reset_outputs();
        check("rst_req_ready", req_ready, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_a_opcode", a_opcode, 0);
        check("rst_a_param", a_param, 0);
        check("rst_a_source", a_source, 0);
        check("rst_a_address", a_address, 0);
        check("rst_a_mask", a_mask, 0);
        check("rst_a_data", a_data, 0);
    endtask

    task automatic check_a_fields();
        check("a_valid", a_valid, 1);
        check("a_opcode", a_opcode, model_opcode());
        check("a_param", a_param, 0);
        check("a_size", a_size, 2);
        check("a_source", a_source, exp_src % 256);
        check("a_address", a_address, cur_addr);
        check("a_mask", a_mask, cur_write ? cur_mask : 4'hF);
        check("a_data", a_data, cur_write ? cur_wdata : 32'h0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge where A_SEND is visible.
    task automatic issue_req(input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [MW-1:0] mask);
        cur_write = wr; cur_addr = addr; cur_wdata = wdata; cur_mask = mask;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_mask = mask;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_mask = 4'($urandom);
        check_a_fields();
    endtask

    // Stall the A handshake, poking req_valid/d_valid which must both be ignored meanwhile.
    task automatic a_accept(input int stall);
        for (int i = 0; i < stall; i++) begin
            a_ready = 1'b0; req_valid = 1'b1; d_valid = 1'b1;
            @(negedge clk);
            check_a_fields();
            check("req_ready_busy", req_ready, 0);
            check("d_ready_asend", d_ready, 0);
        end
        req_valid = 1'b0; d_valid = 1'b0; a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        check("a_valid_drop", a_valid, 0);
        check("d_ready_dwait", d_ready, 1);
        check("rsp_valid_dwait", rsp_valid, 0);
    endtask

    task automatic d_respond(input int wait_cyc, input logic [2:0] op, input logic [SRCW-1:0] src,
                             input logic [DW-1:0] data, input logic err);
        logic exp_err;
        for (int i = 0; i < wait_cyc; i++) @(negedge clk);
        d_valid = 1'b1; d_opcode = op; d_source = src; d_data = data; d_error = err;
        @(negedge clk);
        d_valid = 1'b0; d_error = 1'b0;
        exp_err = err | (int'(src) != exp_src % 256) | (cur_write ? (op != 3'd0) : (op != 3'd1));
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, (op == 3'd1) ? data : 32'h0);
        check("rsp_error", rsp_error, exp_err);
        check("d_ready_rsp", d_ready, 0);
    endtask

    task automatic rsp_accept(input int hold);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("rsp_valid_hold", rsp_valid, 1);
            check("req_ready_rsp", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
        exp_src = (exp_src + 1) % 256;
    endtask

    initial begin
        logic          wr, err;
        logic [MW-1:0] mask;
        logic [2:0]    op;
        logic [SRCW-1:0] src;

        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_mask = 0;
        rsp_ready = 0; a_ready = 0;
        d_valid = 0; d_opcode = 0; d_source = 0; d_data = 0; d_error = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Full write, zero-wait slave.
        issue_req(1'b1, 32'h0, 32'h0000_00A5, 4'hF);
        a_accept(0);
        d_respond(0, 3'd0, 8'(exp_src), 32'hDEAD_BEEF, 1'b0);
        rsp_accept(0);

        // Read with A backpressure and response hold-off.
        issue_req(1'b0, 32'h0000_0010, 32'h1234_5678, 4'h3);
        a_accept(3);
        d_respond(1, 3'd1, 8'(exp_src), 32'h0000_005A, 1'b0);
        rsp_accept(2);

        // Source mismatch, slave error, wrong ack type for a Get.
        issue_req(1'b1, 32'h4, 32'h1, 4'hF);
        a_accept(0);
        d_respond(0, 3'd0, 8'd7, 32'h0, 1'b0);
        rsp_accept(0);
        issue_req(1'b0, 32'h8, 32'h0, 4'hF);
        a_accept(1);
        d_respond(0, 3'd1, 8'(exp_src), 32'hCAFE_0001, 1'b1);
        rsp_accept(1);
        issue_req(1'b0, 32'hC, 32'h0, 4'hF);
        a_accept(0);
        d_respond(0, 3'd0, 8'(exp_src), 32'h0, 1'b0);
        rsp_accept(0);

        // Partial write.
        issue_req(1'b1, 32'h0, 32'h0000_0011, 4'h1);
        a_accept(0);
        d_respond(0, 3'd0, 8'(exp_src), 32'h0, 1'b0);
        rsp_accept(0);

        // Random traffic; enough transactions to wrap the 8-bit source ID.
        for (int n = 0; n < 260; n++) begin
            wr = 1'($urandom);
            mask = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            issue_req(wr, $urandom, $urandom, mask);
            a_accept($urandom_range(0, 2));
            op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : (wr ? 3'd0 : 3'd1);
            src = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(exp_src);
            err = ($urandom_range(0, 9) == 0);
            d_respond($urandom_range(0, 2), op, src, $urandom, err);
            rsp_accept($urandom_range(0, 2));
        end

        // Timeout: no D beat, RSP four cycles after the A handshake; a late beat is refused.
        issue_req(1'b0, 32'h20, 32'h0, 4'hF);
        a_accept(0);
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clk);
            check("tmo_not_yet", rsp_valid, 0);
            check("tmo_d_ready", d_ready, 1);
        end
        @(negedge clk);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_error", rsp_error, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        d_valid = 1'b1; d_opcode = 3'd1; d_source = 8'(exp_src); d_data = 32'h7777_7777;
        @(negedge clk);
        check("late_d_ready", d_ready, 0);
        check("late_rsp_rdata", rsp_rdata, 0);
        check("late_rsp_valid", rsp_valid, 1);
        d_valid = 1'b0;
        rsp_accept(0);

        // Asynchronous reset in D_WAIT abandons the transaction; source restarts at 0.
        issue_req(1'b1, 32'h30, 32'h55, 4'hF);
        a_accept(0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        exp_src = 0;
        @(negedge clk);
        issue_req(1'b0, 32'h40, 32'h0, 4'hF);
        a_accept(0);
        d_respond(0, 3'd1, 8'd0, 32'h0000_0099, 1'b0);
        rsp_accept(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
